// File: rtl/qlab5_mem_pattern_tester.sv
// Memory self-test master: writes seed+address to every word, reads it all back and
// reports mismatch count and the first failing address.
module qlab5_mem_pattern_tester #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2048
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_W-1:0]     pattern_seed,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [15:0]           err_count,
  output logic [ADDR_W-1:0]     first_err_addr,
  output logic [ADDR_W-1:0]     mem_address,
  output logic [DATA_W/8-1:0]   mem_byteenable,
  output logic                  mem_chipselect,
  output logic                  mem_write,
  output logic [DATA_W-1:0]     mem_writedata,
  output logic                  mem_clken,
  input  logic [DATA_W-1:0]     mem_readdata
);

  // state  | meaning
  // IDLE   | waiting for start, no results
  // WRITE  | writing pattern to words 0..DEPTH-1
  // READ   | reading words back, comparing one cycle behind
  // DRAIN  | final compare of the last read word
  // DONE   | results held until the next start
  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   addr;
  logic [ADDR_W-1:0]   cmp_addr;
  logic                cmp_valid;
  logic [DATA_W-1:0]   seed;
  logic                start_ok;
  logic                addr_last;
  logic                mismatch;

  assign start_ok  = start && ((state == S_IDLE) || (state == S_DONE));
  assign addr_last = (addr == LAST_ADDR);
  assign mismatch  = cmp_valid && (mem_readdata != (seed + DATA_W'(cmp_addr)));

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start_ok) state_nxt = S_WRITE;
      S_WRITE: if (addr_last) state_nxt = S_READ;
      S_READ:  if (addr_last) state_nxt = S_DRAIN;
      S_DRAIN: state_nxt = S_DONE;
      S_DONE:  if (start_ok) state_nxt = S_WRITE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy           = 1'b0;
    done           = 1'b0;
    pass           = 1'b0;
    mem_chipselect = 1'b0;
    mem_write      = 1'b0;
    mem_writedata  = '0;
    case (state)
      S_WRITE: begin
        busy           = 1'b1;
        mem_chipselect = 1'b1;
        mem_write      = 1'b1;
        mem_writedata  = seed + DATA_W'(addr);
      end
      S_READ: begin
        busy           = 1'b1;
        mem_chipselect = 1'b1;
      end
      S_DRAIN: busy = 1'b1;
      S_DONE: begin
        done = 1'b1;
        pass = (err_count == 16'd0);
      end
      default: ;
    endcase
  end

  assign mem_address    = addr;
  assign mem_byteenable = '1;
  assign mem_clken      = 1'b1;

  // Address reloads to 0 at the end of each pass so it never exceeds DEPTH-1.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr           <= '0;
      seed           <= '0;
      cmp_valid      <= 1'b0;
      cmp_addr       <= '0;
      err_count      <= '0;
      first_err_addr <= '0;
    end else begin
      cmp_valid <= (state == S_READ);
      cmp_addr  <= addr;
      if (start_ok) begin
        addr           <= '0;
        seed           <= pattern_seed;
        err_count      <= '0;
        first_err_addr <= '0;
      end else begin
        if ((state == S_WRITE) || (state == S_READ))
          addr <= addr_last ? '0 : addr + 1'b1;
        if (mismatch) begin
          if (err_count == 16'd0) first_err_addr <= cmp_addr;
          if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_qlab5_mem_pattern_tester.sv
// Scoreboard bench for qlab5_mem_pattern_tester with a 16-word RAM model that can
// corrupt selected words on read.
module tb_qlab5_mem_pattern_tester;
  localparam int AW = 4;
  localparam int DW = 32;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [DW-1:0] pattern_seed = '0;
  logic          busy, done, pass;
  logic [15:0]   err_count;
  logic [AW-1:0] first_err_addr, mem_address;
  logic [DW/8-1:0] mem_byteenable;
  logic          mem_chipselect, mem_write, mem_clken;
  logic [DW-1:0] mem_writedata;
  logic [DW-1:0] mem_readdata = '0;

  qlab5_mem_pattern_tester #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .start(start), .pattern_seed(pattern_seed),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_err_addr(first_err_addr), .mem_address(mem_address),
    .mem_byteenable(mem_byteenable), .mem_chipselect(mem_chipselect),
    .mem_write(mem_write), .mem_writedata(mem_writedata), .mem_clken(mem_clken),
    .mem_readdata(mem_readdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] ram  [DEPTH];
  logic [DW-1:0] flip [DEPTH];

  always @(posedge clk) begin
    if (mem_chipselect && mem_write) ram[mem_address] <= mem_writedata;
    else if (mem_chipselect)         mem_readdata <= ram[mem_address] ^ flip[mem_address];
  end

  typedef struct packed { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
  typedef struct packed { int cyc; logic pass; logic [15:0] errs; logic [AW-1:0] first; } res_t;
  wr_t           wq[$];
  logic [AW-1:0] rq[$];
  res_t          resq[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  logic done_q = 1'b0;
  always @(negedge clk) begin
    wr_t  w;
    res_t r;
    logic [AW-1:0] ra;
    if (mem_chipselect) begin
      if (mem_write) begin
        if (wq.size() == 0) fail("unexpected_write");
        else begin
          w = wq.pop_front();
          chk("wr_addr", mem_address, w.a);
          chk("wr_data", mem_writedata, w.d);
        end
      end else begin
        if (rq.size() == 0) fail("unexpected_read");
        else begin
          ra = rq.pop_front();
          chk("rd_addr", mem_address, ra);
        end
      end
    end
    if (done && !done_q) begin
      if (resq.size() == 0) fail("unexpected_done");
      else begin
        r = resq.pop_front();
        chk("done_cycle", cyc, r.cyc);
        chk("pass", pass, r.pass);
        chk("err_count", err_count, r.errs);
        chk("first_err_addr", first_err_addr, r.first);
        chk("no_x", $isunknown({busy, pass, err_count, first_err_addr, mem_address,
                                mem_chipselect, mem_write, mem_writedata}), 0);
      end
    end
    done_q = done;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Cycle k of a run follows edge k-1, where edge 0 accepts start.
  task automatic run(input logic [DW-1:0] seed, input int p1, input int p2, input int rst_at);
    int   accept;
    int   n;
    int   k;
    bit   rst_now;
    res_t r;
    start = 1'b1;
    pattern_seed = seed;
    accept = cyc + 1;
    r.errs = '0;
    r.first = '0;
    for (int a = 0; a < DEPTH; a++) begin
      wq.push_back('{a: AW'(a), d: DW'(seed + DW'(a))});
      rq.push_back(AW'(a));
      if (flip[a] != '0) begin
        if (r.errs == 0) r.first = AW'(a);
        r.errs = r.errs + 16'd1;
      end
    end
    r.pass = (r.errs == 0);
    r.cyc = accept + 2 * DEPTH + 1;
    resq.push_back(r);
    tick();
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    n = 0;
    while (!done && n < 200) begin
      k = cyc - accept + 1;
      start = (k == p1) || (k == p2);
      if (start) pattern_seed = $urandom;
      rst_now = (k == rst_at);
      reset = rst_now;
      tick();
      n++;
      if (rst_now) begin
        reset = 1'b0;
        start = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_chipselect", mem_chipselect, 0);
        chk("rst_write", mem_write, 0);
        chk("rst_err_count", err_count, 0);
        chk("rst_done", done, 0);
        wq.delete();
        rq.delete();
        resq.delete();
        return;
      end
    end
    start = 1'b0;
    if (!done) fail("done_timeout");
  endtask

  task automatic clear_flips();
    for (int a = 0; a < DEPTH; a++) flip[a] = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    clear_flips();
    reset = 1'b1;
    repeat (3) tick();
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_pass", pass, 0);
    chk("reset_err_count", err_count, 0);
    chk("reset_first_err", first_err_addr, 0);
    chk("reset_chipselect", mem_chipselect, 0);
    chk("reset_write", mem_write, 0);
    chk("reset_address", mem_address, 0);
    chk("reset_writedata", mem_writedata, 0);
    chk("byteenable", mem_byteenable, 4'hF);
    chk("clken", mem_clken, 1);
    reset = 1'b0;
    tick();

    run(32'h1000_0000, 0, 0, 0);
    flip[5] = 32'h1;
    run($urandom, 0, 0, 0);
    clear_flips();
    flip[3] = 32'h1; flip[9] = 32'h8000_0000; flip[12] = 32'h0001_0000;
    run($urandom, 0, 0, 0);
    clear_flips();
    run(32'hFFFF_FFFF, 0, 0, 0);
    run(32'h0BAD_F00D, 1, 20, 0);
    run(32'h5555_AAAA, 0, 0, 10);
    run(32'h5555_AAAA, 0, 0, 0);

    repeat (8) begin
      for (int a = 0; a < DEPTH; a++)
        flip[a] = ($urandom_range(0, 3) == 0) ? ($urandom | 32'h1) : '0;
      run($urandom, $urandom_range(0, 33), $urandom_range(0, 33), 0);
    end

    repeat (4) tick();
    if (wq.size() != 0 || rq.size() != 0 || resq.size() != 0) fail("scoreboard_not_empty");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
